// File: rtl/imem_axi_ar_ctrl.sv
// imem_axi_ar_ctrl: AXI read-address sequencer and arbiter for the I-fetch line refill path.
// It accepts demand and prefetch line requests, with demand always taking priority.
// It issues one 8-beat INCR burst of 64-bit beats and tracks the R channel until rlast.
// It reports the fill source and the done, error and discard status of each burst.
// Optional build macro IMEM_AR_TIMEOUT_EN adds a 16-bit watchdog and a terminal HUNG state.
module imem_axi_ar_ctrl #(
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              axi_clk,
  input  logic              axi_resetn,
  input  logic              dmd_req_i,
  input  logic [ADDR_W-1:0] dmd_addr_i,
  output logic              dmd_gnt_o,
  input  logic              pf_req_i,
  input  logic [ADDR_W-1:0] pf_addr_i,
  output logic              pf_gnt_o,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [7:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic              rvalid_i,
  input  logic              rready_i,
  input  logic              rlast_i,
  input  logic [1:0]        rresp_i,
  output logic              busy_o,
  output logic              fill_src_o,
  output logic              fill_done_o,
  output logic              fill_err_o,
  output logic              fill_discard_o,
  output logic              exc_valid_o,
  output logic [4:0]        exc_code_o
);

  // The watchdog counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be within 2..65536");
  end

  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(63));

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3,
    HUNG = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              grant;
  logic              beat;
  logic              progress;
  logic [ADDR_W-1:0] sel_addr;
  logic              err_q;
  logic              disc_q;
  logic [3:0]        beat_cnt;

  // Grants are combinational and only offered in IDLE; a flush suppresses both grants.
  assign dmd_gnt_o = (state == IDLE) & dmd_req_i & ~flush_i;
  assign pf_gnt_o  = (state == IDLE) & pf_req_i & ~dmd_req_i & ~flush_i;
  assign grant     = dmd_gnt_o | pf_gnt_o;
  assign sel_addr  = dmd_gnt_o ? dmd_addr_i : pf_addr_i;

  // Beats seen before the AR handshake (i.e. outside DATA) are ignored.
  assign beat     = (state == DATA) & rvalid_i & rready_i;
  assign progress = ((state == ADDR) & arready_i) | beat;

`ifdef IMEM_AR_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        wd_expire;

  assign wd_expire = ((state == ADDR) | (state == DATA)) & ~progress &
                     (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog counts stalled ADDR/DATA cycles; any grant, AR handshake or beat restarts it.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wd_cnt <= '0;
    end else if (grant || progress) begin
      wd_cnt <= '0;
    end else if (state == ADDR || state == DATA) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign exc_valid_o = (state == HUNG);
`else
  assign exc_valid_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one burst in flight; AR is never retracted, even on flush.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant) state_nxt = ADDR;
      ADDR: if (arready_i) state_nxt = DATA;
      DATA: if (beat && rlast_i) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = state;
    endcase
`ifdef IMEM_AR_TIMEOUT_EN
    if (wd_expire) state_nxt = HUNG;
`endif
  end

  // Burst context: the address and source are latched on grant; error and discard
  // status accumulate until the next grant.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      araddr_o   <= '0;
      fill_src_o <= 1'b0;
      err_q      <= 1'b0;
      disc_q     <= 1'b0;
      beat_cnt   <= '0;
    end else if (grant) begin
      araddr_o   <= sel_addr & LINE_MASK;
      fill_src_o <= pf_gnt_o;
      err_q      <= 1'b0;
      disc_q     <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      if (flush_i && (state == ADDR || state == DATA || state == DONE)) disc_q <= 1'b1;
      if (beat) begin
        beat_cnt <= beat_cnt + 4'd1;
        if (rresp_i != 2'b00) err_q <= 1'b1;
        // rlast must arrive on exactly the 8th beat; an 8th or later beat without rlast is an overrun.
        if (rlast_i && beat_cnt != 4'd7) err_q <= 1'b1;
        if (!rlast_i && beat_cnt >= 4'd7) err_q <= 1'b1;
      end
    end
  end

  assign arlen_o        = 8'd7;
  assign arsize_o       = 3'b011;
  assign arburst_o      = 2'b01;
  assign exc_code_o     = 5'b00001;
  assign arvalid_o      = (state == ADDR);
  assign busy_o         = (state != IDLE);
  assign fill_done_o    = (state == DONE);
  assign fill_err_o     = fill_done_o & err_q;
  assign fill_discard_o = fill_done_o & disc_q;

endmodule
